// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths and the MEM-stage stall sequencer state encoding.
package cpu_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    MSC_IDLE = 2'd0,
    MSC_BUSY = 2'd1,
    MSC_DONE = 2'd2
  } msc_state_t;
endpackage

// File: rtl/mem_stall_ctrl_timer.sv
// Saturating counter of BUSY cycles; expired flags the abort point for a silent memory.
module stall_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // clear preloads 1 so the value equals the index of the current BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= CW'(1);
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);
endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack access per load/store and stalls the pipeline
// until it completes, releasing for exactly one DONE cycle with the load data.
module mem_stall_ctrl #(
  parameter int ADDR_WIDTH     = cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUOutM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  stop,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_timeout
);
  import cpu_pkg::*;

  msc_state_t state, next_state;
  logic       req_in;
  logic       timer_clear;
  logic       timer_en;
  logic       expired;

  assign req_in      = MemReadM | MemWriteM;
  assign timer_clear = (state == MSC_IDLE) && req_in;
  assign timer_en    = (state == MSC_BUSY);

  stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MSC_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    stop       = 1'b0;
    case (state)
      MSC_IDLE: begin
        stop = req_in;
        if (req_in) next_state = MSC_BUSY;
      end
      MSC_BUSY: begin
        stop = 1'b1;
        if (mem_ack || expired) next_state = MSC_DONE;
      end
      MSC_DONE: next_state = MSC_IDLE;
      default:  next_state = MSC_IDLE;
    endcase
    // reset must silence the hazard unit even while the MEM inputs are still asserted
    if (rst) stop = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ReadDataM   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        MSC_IDLE: begin
          if (req_in) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUOutM;
            mem_wdata <= WriteDataM;
          end
        end
        MSC_BUSY: begin
          // ack takes priority over a timeout landing in the same cycle
          if (mem_ack) begin
            mem_req   <= 1'b0;
            ReadDataM <= mem_we ? '0 : mem_rdata;
          end else if (expired) begin
            mem_req     <= 1'b0;
            ReadDataM   <= '0;
            mem_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: vector table driven through a scoreboard plus reset/idle-ack sequences.
module tb_mem_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [15:0] ALUOutM, WriteDataM;
  logic        stop;
  logic [15:0] ReadDataM;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_timeout;

  int total = 0;
  int bad   = 0;

  mem_stall_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .stop       (stop),
    .ReadDataM  (ReadDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ack_at;     // BUSY cycle carrying the ack, 0 = never
    logic [15:0] rdata;
    logic        b2b;        // next vector issues in the IDLE cycle right after DONE
    logic        exp_we;
    logic [15:0] exp_rdata;
    logic        exp_to;
    int          exp_busy;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        to;
    int          busy;
    int          stall;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_idle();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUOutM    = 16'h0;
    WriteDataM = 16'h0;
  endtask

  // entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE
  task automatic run_txn(input vec_t v);
    exp_t e, got;
    int   stall = 0;
    int   busy  = 0;
    bit   done  = 0;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    ALUOutM    = v.addr;
    WriteDataM = v.wdata;
    e.rdata = v.exp_rdata; e.to = v.exp_to; e.busy = v.exp_busy; e.stall = v.exp_stall;
    sb.push_back(e);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stop === 1'b1) stall++;
      if (mem_req === 1'b1) begin
        busy++;
        check("mem_addr", mem_addr, v.addr);
        check("mem_we", mem_we, v.exp_we);
        check("mem_wdata", mem_wdata, v.wdata);
        mem_ack   = (busy == v.ack_at);
        mem_rdata = v.rdata;
      end else begin
        mem_ack = 1'b0;
        if (busy > 0) done = 1;
      end
      if (done) begin
        if (sb.size() > 0) begin
          got = sb.pop_front();
          check("done_rdata", ReadDataM, got.rdata);
          check("done_timeout", mem_timeout, got.to);
          check("busy_cycles", busy, got.busy);
          check("stall_cycles", stall, got.stall);
        end else begin
          check("scoreboard_empty", 0, 1);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      check("txn_no_done", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;
    if (!v.b2b) begin
      drive_idle();
      #1;
      check("no_reissue_req", mem_req, 0);
      check("no_reissue_stop", stop, 0);
      check("rdata_hold", ReadDataM, v.exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rd    wr    addr      wdata     ack rdata     b2b   we    rdata     to  busy stall
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000,  1, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0,  1,  2};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234,  4, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b0,  4,  5};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000,  2, 16'hA5A5, 1'b1, 1'b0, 16'hA5A5, 1'b0,  2,  3};
    vecs[3] = '{1'b0, 1'b1, 16'h0102, 16'hCAFE,  1, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0,  1,  2};
    vecs[4] = '{1'b1, 1'b1, 16'h0200, 16'h7777,  3, 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b0,  3,  4};
    vecs[5] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 15, 16'h1357, 1'b0, 1'b0, 16'h1357, 1'b0, 15, 16};
    vecs[6] = '{1'b1, 1'b0, 16'h0400, 16'h0000,  0, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b1, 15, 16};
    vecs[7] = '{1'b1, 1'b0, 16'h0500, 16'h0000,  1, 16'h2468, 1'b0, 1'b0, 16'h2468, 1'b1,  1,  2};

    rst = 1'b1;
    drive_idle();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stop", stop, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_timeout", mem_timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    // stray acks while IDLE
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle_ack_req", mem_req, 0);
      check("idle_ack_stop", stop, 0);
      check("idle_ack_rdata", ReadDataM, 0);
    end
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // asynchronous reset while BUSY, then a late ack
    MemReadM = 1'b1;
    ALUOutM  = 16'h0600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", mem_req, 1);
    check("pre_rst_timeout", mem_timeout, 1);
    rst = 1'b1;
    #1;
    check("async_rst_stop", stop, 0);
    check("async_rst_req", mem_req, 0);
    check("async_rst_addr", mem_addr, 0);
    check("async_rst_timeout", mem_timeout, 0);
    drive_idle();
    @(negedge clk);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h4321;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("post_rst_ack_req", mem_req, 0);
    check("post_rst_ack_stop", stop, 0);
    check("post_rst_ack_rdata", ReadDataM, 0);
    @(posedge clk); #1;
    check("post_rst_idle_req", mem_req, 0);
    check("post_rst_idle_timeout", mem_timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
